// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 codes, requester ids,
// the first pipeline stage control struct and the access screening helper.
package dmem_pkg;

    localparam int F3_W = 3;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    localparam int NUM_PORTS = 2;

    // Control half of stage S1; address and data live beside it, sized by the
    // top-level parameters.
    typedef struct packed {
        logic            valid;
        logic            id;
        logic            we;
        logic [F3_W-1:0] funct3;
        logic            err;
    } s1_ctrl_t;

    function automatic logic access_err(
        input logic [F3_W-1:0] funct3,
        input logic [1:0]      addr_lo,
        input logic            out_of_range
    );
        logic bad_shape;
        case (funct3)
            F3_LB, F3_LBU: bad_shape = 1'b0;
            F3_LW:         bad_shape = (addr_lo != 2'b00);
            default:       bad_shape = 1'b1;
        endcase
        return bad_shape | out_of_range;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's request/response bundle; master is the requester side,
// slave is the arbiter side.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// Two-way grant selection. Fixed m0 priority by default; defining
// DMEM_ARB_RR_EN switches to round-robin with a last-grant pointer.
module dmem_arb_pick
    import dmem_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
    logic last_r;

    // Last-grant pointer; reset value makes m0 win the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= ID_M1;
        end else if (grant != 2'b00) begin
            last_r <= grant[ID_M1];
        end else begin
            last_r <= last_r;
        end
    end

    // On conflict the port not granted last wins.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_r == ID_M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
`else
    // Fixed priority, m0 highest.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = 2'b01;
            default: grant = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Optional round-robin arbitration is selected with DMEM_ARB_RR_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         m0,
    dmem_arbiter_if.slave         m1,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_SIZE * 32'sd4);

    logic [1:0]            valid_s;
    logic [1:0]            grant_s;
    logic                  accept_s;
    logic                  sel_id_s;
    logic                  sel_we_s;
    logic [2:0]            sel_funct3_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;
    logic                  sel_err_s;

    s1_ctrl_t              s1_r;
    logic [ADDR_WIDTH-1:0] s1_addr_r;
    logic [DATA_WIDTH-1:0] s1_wdata_r;
    logic                  mem_wr_en_r;

    logic [1:0]            rsp_hit_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic [1:0]            rsp_valid_r;
    logic [1:0]            rsp_err_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r [NUM_PORTS];

    assign valid_s = {m1.req_valid, m0.req_valid};

    dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
        .clk   (clk),
        .rst   (rst),
`endif
        .valid (valid_s),
        .grant (grant_s)
    );

    assign m0.req_ready = grant_s[ID_M0];
    assign m1.req_ready = grant_s[ID_M1];
    assign accept_s     = |grant_s;

    // Route the granted request's fields and screen it before it can reach memory.
    always_comb begin
        sel_id_s     = ID_M0;
        sel_we_s     = m0.req_we;
        sel_funct3_s = m0.req_funct3;
        sel_addr_s   = m0.req_addr;
        sel_wdata_s  = m0.req_wdata;
        if (grant_s[ID_M1]) begin
            sel_id_s     = ID_M1;
            sel_we_s     = m1.req_we;
            sel_funct3_s = m1.req_funct3;
            sel_addr_s   = m1.req_addr;
            sel_wdata_s  = m1.req_wdata;
        end else begin
            sel_id_s     = ID_M0;
        end
        sel_err_s = access_err(sel_funct3_s, sel_addr_s[1:0], sel_addr_s >= ADDR_LIMIT);
    end

    // Stage S1: address/data only load on accept so the memory bus holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r        <= '0;
            s1_addr_r   <= '0;
            s1_wdata_r  <= '0;
            mem_wr_en_r <= 1'b0;
        end else if (accept_s) begin
            s1_r.valid  <= 1'b1;
            s1_r.id     <= sel_id_s;
            s1_r.we     <= sel_we_s;
            s1_r.funct3 <= sel_funct3_s;
            s1_r.err    <= sel_err_s;
            s1_addr_r   <= sel_addr_s;
            s1_wdata_r  <= sel_wdata_s;
            mem_wr_en_r <= sel_we_s & ~sel_err_s;
        end else begin
            s1_r.valid  <= 1'b0;
            mem_wr_en_r <= 1'b0;
        end
    end

    assign mem_wr_en   = mem_wr_en_r;
    assign mem_funct3  = s1_r.funct3;
    assign mem_addr    = s1_addr_r;
    assign mem_wr_data = s1_wdata_r;

    // Load data is only captured for clean loads; stores and rejects return zero.
    always_comb begin
        rsp_hit_s[ID_M0] = s1_r.valid & (s1_r.id == ID_M0);
        rsp_hit_s[ID_M1] = s1_r.valid & (s1_r.id == ID_M1);
        if (s1_r.valid & ~s1_r.we & ~s1_r.err) begin
            load_data_s = mem_rd_data;
        end else begin
            load_data_s = '0;
        end
    end

    // Response stage, steered to the requester recorded in S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 2'b00;
            rsp_err_r   <= 2'b00;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rsp_rdata_r[i] <= '0;
            end
        end else begin
            rsp_valid_r <= rsp_hit_s;
            rsp_err_r   <= rsp_hit_s & {2{s1_r.err}};
            for (int i = 0; i < NUM_PORTS; i++) begin
                rsp_rdata_r[i] <= rsp_hit_s[i] ? load_data_s : '0;
            end
        end
    end

    assign m0.rsp_valid = rsp_valid_r[ID_M0];
    assign m0.rsp_err   = rsp_err_r[ID_M0];
    assign m0.rsp_rdata = rsp_rdata_r[ID_M0];
    assign m1.rsp_valid = rsp_valid_r[ID_M1];
    assign m1.rsp_err   = rsp_err_r[ID_M1];
    assign m1.rsp_rdata = rsp_rdata_r[ID_M1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps plus random traffic,
// compared against a transaction-level model of memory and arbitration.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m0_if ();
    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m1_if ();

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .mem_wr_en   (mem_wr_en),
        .mem_funct3  (mem_funct3),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Requester drive state, one slot per port
    logic        p_valid [2];
    logic        p_we    [2];
    logic [2:0]  p_f3    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];

    assign m0_if.req_valid  = p_valid[0];
    assign m0_if.req_we     = p_we[0];
    assign m0_if.req_funct3 = p_f3[0];
    assign m0_if.req_addr   = p_addr[0];
    assign m0_if.req_wdata  = p_wdata[0];
    assign m1_if.req_valid  = p_valid[1];
    assign m1_if.req_we     = p_we[1];
    assign m1_if.req_funct3 = p_f3[1];
    assign m1_if.req_addr   = p_addr[1];
    assign m1_if.req_wdata  = p_wdata[1];

    logic        o_rdy [2];
    logic        o_rv  [2];
    logic        o_re  [2];
    logic [31:0] o_rd  [2];

    always_comb begin
        o_rdy[0] = m0_if.req_ready;  o_rdy[1] = m1_if.req_ready;
        o_rv[0]  = m0_if.rsp_valid;  o_rv[1]  = m1_if.rsp_valid;
        o_re[0]  = m0_if.rsp_err;    o_re[1]  = m1_if.rsp_err;
        o_rd[0]  = m0_if.rsp_rdata;  o_rd[1]  = m1_if.rsp_rdata;
    end

    // Stand-in for data_mem: 256 bytes, little-endian, combinational read
    logic [7:0] env_mem [256];
    logic       load_img;
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= ref_mem[i];
        end else if (mem_wr_en) begin
            if (mem_funct3 == 3'b010) begin
                for (int k = 0; k < 4; k++) env_mem[{mem_addr[7:2], 2'b00} + 8'(k)] <= mem_wr_data[8*k +: 8];
            end else begin
                env_mem[mem_addr[7:0]] <= mem_wr_data[7:0];
            end
        end
    end

    always_comb begin
        case (mem_funct3)
            3'b000:  mem_rd_data = {{24{env_mem[mem_addr[7:0]][7]}}, env_mem[mem_addr[7:0]]};
            3'b100:  mem_rd_data = {24'h0, env_mem[mem_addr[7:0]]};
            default: mem_rd_data = {env_mem[{mem_addr[7:2], 2'b11}], env_mem[{mem_addr[7:2], 2'b10}],
                                    env_mem[{mem_addr[7:2], 2'b01}], env_mem[{mem_addr[7:2], 2'b00}]};
        endcase
    end

    // Transaction-level expectation for one accepted request
    typedef struct packed {
        logic        v;
        logic        id;
        logic        we;
        logic        err;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] old_word;
    } exp_t;

    exp_t        s1, s2;
    logic [31:0] hold_addr, hold_wdata;
    logic [2:0]  hold_f3;
    int          grants [2];
    int          n_assert, n_fail;
`ifdef DMEM_ARB_RR_EN
    int          rr_last;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic model_err(input logic [2:0] f3, input logic [31:0] a);
        return !(f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b100)
               || (f3 == 3'b010 && a[1:0] != 2'b00) || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [7:0] base;
        base = {a[7:2], 2'b00};
        return {ref_mem[base + 8'd3], ref_mem[base + 8'd2], ref_mem[base + 8'd1], ref_mem[base]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] b;
        b = ref_mem[a[7:0]];
        if (f3 == 3'b000) return {{24{b[7]}}, b};
        if (f3 == 3'b100) return {24'h0, b};
        return ref_word(a);
    endfunction

    task automatic put(input int p, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        p_valid[p] = 1'b1; p_we[p] = we; p_f3[p] = f3; p_addr[p] = a; p_wdata[p] = wd;
    endtask

    // One cycle: check outputs at the falling edge, then retire the accept
    task automatic tick();
        exp_t nx;
        int   id;
        logic [7:0] base;
        @(negedge clk);
        chk("mem_wr_en", {31'h0, mem_wr_en}, {31'h0, s1.v & s1.we & ~s1.err});
        chk("mem_addr", mem_addr, hold_addr);
        chk("mem_funct3", {29'h0, mem_funct3}, {29'h0, hold_f3});
        chk("mem_wr_data", mem_wr_data, hold_wdata);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rsp_valid%0d", p), {31'h0, o_rv[p]}, {31'h0, s2.v && s2.id == 1'(p)});
            chk($sformatf("rsp_err%0d", p), {31'h0, o_re[p]}, {31'h0, s2.v && s2.id == 1'(p) && s2.err});
            chk($sformatf("rsp_rdata%0d", p), o_rd[p], (s2.v && s2.id == 1'(p)) ? s2.rdata : 32'h0);
        end
        id = -1;
        if (p_valid[0] && p_valid[1]) begin
`ifdef DMEM_ARB_RR_EN
            id = (rr_last == 0) ? 1 : 0;
`else
            id = 0;
`endif
        end else if (p_valid[0]) begin
            id = 0;
        end else if (p_valid[1]) begin
            id = 1;
        end
        chk("m0_req_ready", {31'h0, o_rdy[0]}, {31'h0, id == 0});
        chk("m1_req_ready", {31'h0, o_rdy[1]}, {31'h0, id == 1});
        nx = '0;
        if (id >= 0) begin
            nx.v = 1'b1; nx.id = 1'(id); nx.we = p_we[id]; nx.f3 = p_f3[id];
            nx.addr = p_addr[id]; nx.wdata = p_wdata[id];
            nx.err = model_err(nx.f3, nx.addr);
            nx.old_word = ref_word(nx.addr);
            if (nx.we && !nx.err) begin
                base = {nx.addr[7:2], 2'b00};
                if (nx.f3 == 3'b010) begin
                    for (int k = 0; k < 4; k++) ref_mem[base + 8'(k)] = nx.wdata[8*k +: 8];
                end else begin
                    ref_mem[nx.addr[7:0]] = nx.wdata[7:0];
                end
            end
            if (!nx.we && !nx.err) nx.rdata = ref_load(nx.f3, nx.addr);
            grants[id]++;
`ifdef DMEM_ARB_RR_EN
            rr_last = id;
`endif
        end
        @(posedge clk);
        #1;
        s2 = s1;
        s1 = nx;
        if (id >= 0) begin
            hold_addr = nx.addr; hold_f3 = nx.f3; hold_wdata = nx.wdata;
            p_valid[id] = 1'b0;
        end
    endtask

    task automatic model_reset();
        if (s1.v && s1.we && !s1.err) begin
            for (int k = 0; k < 4; k++) ref_mem[{s1.addr[7:2], 2'b00} + 8'(k)] = s1.old_word[8*k +: 8];
        end
        s1 = '0; s2 = '0;
        hold_addr = 32'h0; hold_f3 = 3'b000; hold_wdata = 32'h0;
        for (int p = 0; p < 2; p++) p_valid[p] = 1'b0;
`ifdef DMEM_ARB_RR_EN
        rr_last = 1;
`endif
    endtask

    task automatic chk_reset_outputs();
        chk("rst mem_wr_en", {31'h0, mem_wr_en}, 32'h0);
        chk("rst mem_funct3", {29'h0, mem_funct3}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wr_data", mem_wr_data, 32'h0);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst rsp_valid%0d", p), {31'h0, o_rv[p]}, 32'h0);
            chk($sformatf("rst rsp_err%0d", p), {31'h0, o_re[p]}, 32'h0);
            chk($sformatf("rst rsp_rdata%0d", p), o_rd[p], 32'h0);
            chk($sformatf("rst req_ready%0d", p), {31'h0, o_rdy[p]}, 32'h0);
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        we;
        n_assert = 0; n_fail = 0;
        grants[0] = 0; grants[1] = 0;
        for (int p = 0; p < 2; p++) begin
            p_we[p] = 1'b0; p_f3[p] = 3'b000; p_addr[p] = 32'h0; p_wdata[p] = 32'h0;
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        model_reset();
        rst = 1'b1;
        load_img = 1'b1;
        @(posedge clk);
        @(posedge clk);
        load_img = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // Store then load back the word
        put(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        tick();
        put(0, 1'b0, 3'b010, 32'h10, 32'h0);
        tick(); tick(); tick();

        // Byte store via m1, signed and unsigned byte loads via m0
        put(1, 1'b1, 3'b000, 32'h13, 32'h80);
        tick();
        put(0, 1'b0, 3'b000, 32'h13, 32'h0);
        tick();
        put(0, 1'b0, 3'b100, 32'h13, 32'h0);
        tick(); tick(); tick();

        // Four cycles of contention
        grants[0] = 0; grants[1] = 0;
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 2; p++)
                if (!p_valid[p]) put(p, 1'b0, 3'b010, 32'(4 * $urandom_range(0, 63)), 32'h0);
            tick();
        end
        for (int p = 0; p < 2; p++) p_valid[p] = 1'b0;
`ifdef DMEM_ARB_RR_EN
        chk("contention m0 grants", 32'(grants[0]), 32'd2);
        chk("contention m1 grants", 32'(grants[1]), 32'd2);
`else
        chk("contention m0 grants", 32'(grants[0]), 32'd4);
        chk("contention m1 grants", 32'(grants[1]), 32'd0);
`endif
        tick(); tick();

        // Misaligned word load and out-of-range store, then confirm word 0 untouched
        put(0, 1'b0, 3'b010, 32'h06, 32'h0);
        put(1, 1'b1, 3'b010, 32'h100, 32'h12345678);
        tick(); tick();
        put(0, 1'b0, 3'b010, 32'h0, 32'h0);
        tick();
        put(0, 1'b0, 3'b001, 32'h20, 32'h0);
        tick(); tick(); tick();

        // Reset while a store sits in S1
        put(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
        tick();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        put(0, 1'b0, 3'b010, 32'h40, 32'h0);
        tick(); tick(); tick();

        // Random traffic from both ports
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_valid[p] && $urandom_range(0, 1) == 1) begin
                    we = ($urandom_range(0, 2) == 0);
                    case ($urandom_range(0, 9))
                        0, 1, 2: f3 = 3'b000;
                        3, 4, 5: f3 = 3'b010;
                        6, 7:    f3 = we ? 3'b010 : 3'b100;
                        8:       f3 = 3'b001;
                        default: f3 = 3'($urandom);
                    endcase
                    if (we && f3 == 3'b100) f3 = 3'b000;
                    a = 32'($urandom_range(0, 271));
                    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                    put(p, we, f3, a, $urandom);
                end
            end
            tick();
        end
        for (int p = 0; p < 2; p++) p_valid[p] = 1'b0;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
